dmem_arbiter: RTL and testbench

Shares the single-port, synchronous-read data memory between the two memory-stage slots (M1, M2) of the dual-issue RV32I pipeline. Single-slot and same-word dual-load accesses complete without stall. Two accesses in the same cycle that conflict are serialized in program order (slot 1 first) behind a one-cycle pipeline stall. The block also generates byte enables and store-data lane placement, and formats load data with sign or zero extension for the W stage.

---
 rtl/dmem_pkg.sv | 61 ++++++
 rtl/dmem_fmt.sv | 36 +++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the dual-slot data-memory arbiter.
// Contents: load/store type encodings, arbiter state enum, store lane payload
// struct and the store lane-placement function.
package dmem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LB      = 3'b001,
        LH      = 3'b010,
        LW      = 3'b011,
        LBU     = 3'b100,
        LHU     = 3'b101
    } load_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        SB      = 2'b01,
        SH      = 2'b10,
        SW      = 2'b11
    } store_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    // Byte enables plus lane-placed write data for one store.
    typedef struct packed {
        logic [NBYTES-1:0] we;
        logic [XLEN-1:0]   wdata;
    } wr_lanes_t;

    // Place store data on the RAM byte lanes; replication lets the enables
    // alone pick the target lanes.
    function automatic wr_lanes_t st_lanes(input logic [1:0]      st,
                                           input logic [1:0]      off,
                                           input logic [XLEN-1:0] data);
        wr_lanes_t l;
        l = '0;
        case (st)
            SB: begin
                l.we    = 4'b0001 << off;
                l.wdata = {4{data[7:0]}};
            end
            SH: begin
                l.we    = off[1] ? 4'b1100 : 4'b0011;
                l.wdata = {2{data[15:0]}};
            end
            SW: begin
                l.we    = 4'b1111;
                l.wdata = data;
            end
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dmem_fmt.sv
// Load data formatter: picks the byte/half addressed by the latched offset
// and sign- or zero-extends it.
// Ports: ld_type (load encoding), off (byte offset), raw (RAM word),
//        fmt_data_c (formatted result, combinational).
module dmem_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] fmt_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane select, then extension by load type; unknown types read as zero.
    always_comb begin
        case (off)
            2'd0:    byte_c = raw[7:0];
            2'd1:    byte_c = raw[15:8];
            2'd2:    byte_c = raw[23:16];
            default: byte_c = raw[31:24];
        endcase
        half_c = off[1] ? raw[31:16] : raw[15:0];
        case (ld_type)
            LB:      fmt_data_c = {{24{byte_c[7]}}, byte_c};
            LH:      fmt_data_c = {{16{half_c[15]}}, half_c};
            LW:      fmt_data_c = raw;
            LBU:     fmt_data_c = {24'h0, byte_c};
            LHU:     fmt_data_c = {16'h0, half_c};
            default: fmt_data_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port synchronous-read data RAM between the two
// M-stage slots. Conflicting same-cycle accesses are serialized slot 1 first
// behind a one-cycle stall; same-word dual loads share one access.
// Ports: CLK/NRST; per slot mem_load/mem_store type, result (byte address),
//        reg_data2 (store data); stall to the pipeline; load_dataW1/W2
//        formatted load results; mem_en/mem_we/mem_addr/mem_wdata drive the
//        RAM, mem_rdata returns one cycle after mem_en.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 14
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic [2:0]            mem_loadM1,
    input  logic [1:0]            mem_storeM1,
    input  logic [31:0]           resultM1,
    input  logic [31:0]           reg_data2M1,
    input  logic [2:0]            mem_loadM2,
    input  logic [1:0]            mem_storeM2,
    input  logic [31:0]           resultM2,
    input  logic [31:0]           reg_data2M2,
    output logic                  stall,
    output logic [31:0]           load_dataW1,
    output logic [31:0]           load_dataW2,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    state_e                state_q, state_d;
    logic [2:0]            ld1_q, ld1_d, ld2_q, ld2_d;
    logic [1:0]            off1_q, off1_d, off2_q, off2_d;
    logic [31:0]           hold1_q, hold1_d;
    logic                  sel_hold_q, sel_hold_d;
    logic                  req1_c, req2_c, same_word_c, conflict_c;
    logic [MEM_ADDR_W-1:0] waddr1_c, waddr2_c;
    wr_lanes_t             lanes1_c, lanes2_c;
    logic [31:0]           fmt1_c, fmt2_c;
    logic                  unused_addr_bits;

    assign waddr1_c = resultM1[MEM_ADDR_W+1:2];
    assign waddr2_c = resultM2[MEM_ADDR_W+1:2];
    assign unused_addr_bits = ^{resultM1[31:MEM_ADDR_W+2], resultM2[31:MEM_ADDR_W+2]};

    // Request and conflict decode.
    assign req1_c      = (mem_loadM1 != LD_NONE) || (mem_storeM1 != ST_NONE);
    assign req2_c      = (mem_loadM2 != LD_NONE) || (mem_storeM2 != ST_NONE);
    assign same_word_c = (mem_loadM1 != LD_NONE) && (mem_loadM2 != LD_NONE)
                         && (waddr1_c == waddr2_c);
    assign conflict_c  = req1_c && req2_c && !same_word_c;

    assign lanes1_c = st_lanes(mem_storeM1, resultM1[1:0], reg_data2M1);
    assign lanes2_c = st_lanes(mem_storeM2, resultM2[1:0], reg_data2M2);

    dmem_fmt u_fmt1 (
        .ld_type    (ld1_q),
        .off        (off1_q),
        .raw        (mem_rdata),
        .fmt_data_c (fmt1_c)
    );

    dmem_fmt u_fmt2 (
        .ld_type    (ld2_q),
        .off        (off2_q),
        .raw        (mem_rdata),
        .fmt_data_c (fmt2_c)
    );

    // Slot 1 of a serialized pair is read a cycle early, so present it from hold1.
    assign load_dataW1 = sel_hold_q ? hold1_q : fmt1_c;
    assign load_dataW2 = fmt2_c;

    // Next-state, RAM drive and per-slot latch control.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = '0;
        mem_addr   = waddr1_c;
        mem_wdata  = '0;
        ld1_d      = ld1_q;
        off1_d     = off1_q;
        ld2_d      = ld2_q;
        off2_d     = off2_q;
        hold1_d    = hold1_q;
        sel_hold_d = 1'b0;
        case (state_q)
            IDLE: begin
                ld1_d  = mem_loadM1;
                off1_d = resultM1[1:0];
                ld2_d  = mem_loadM2;
                off2_d = resultM2[1:0];
                if (conflict_c) begin
                    stall   = 1'b1;
                    state_d = SECOND;
                    ld2_d   = LD_NONE;
                end
                if (req1_c) begin
                    mem_en    = 1'b1;
                    mem_we    = lanes1_c.we;
                    mem_wdata = lanes1_c.wdata;
                end else if (req2_c) begin
                    mem_en    = 1'b1;
                    mem_addr  = waddr2_c;
                    mem_we    = lanes2_c.we;
                    mem_wdata = lanes2_c.wdata;
                end
            end
            SECOND: begin
                mem_en     = 1'b1;
                mem_addr   = waddr2_c;
                mem_we     = lanes2_c.we;
                mem_wdata  = lanes2_c.wdata;
                ld2_d      = mem_loadM2;
                off2_d     = resultM2[1:0];
                hold1_d    = fmt1_c;
                sel_hold_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // While reset is held the RAM and pipeline see no activity.
        if (!NRST) begin
            stall  = 1'b0;
            mem_en = 1'b0;
            mem_we = '0;
        end
    end

    // State and per-slot registers.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= IDLE;
            ld1_q      <= LD_NONE;
            ld2_q      <= LD_NONE;
            off1_q     <= '0;
            off2_q     <= '0;
            hold1_q    <= '0;
            sel_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld1_q      <= ld1_d;
            ld2_q      <= ld2_d;
            off1_q     <= off1_d;
            off2_q     <= off2_d;
            hold1_q    <= hold1_d;
            sel_hold_q <= sel_hold_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural read-first RAM.
module tb_dmem_arbiter;

    localparam int unsigned AW = 14;
    localparam logic [2:0] T_NONE = 3'b000, T_LB = 3'b001, T_LH = 3'b010,
                           T_LW = 3'b011, T_LBU = 3'b100, T_LHU = 3'b101;
    localparam logic [1:0] S_NONE = 2'b00, S_SB = 2'b01, S_SH = 2'b10, S_SW = 2'b11;

    logic          CLK = 1'b0;
    logic          NRST = 1'b1;
    logic [2:0]    mem_loadM1 = '0, mem_loadM2 = '0;
    logic [1:0]    mem_storeM1 = '0, mem_storeM2 = '0;
    logic [31:0]   resultM1 = '0, resultM2 = '0, reg_data2M1 = '0, reg_data2M2 = '0;
    logic          stall, mem_en;
    logic [31:0]   load_dataW1, load_dataW2, mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic [31:0]   wmask;
    logic [31:0]   model_mem [4];

    // Observations from the last issue_pair call.
    logic          st0, st1, en0;
    logic [3:0]    we0, we1;
    logic [AW-1:0] ad0;
    logic [31:0]   w1, w2;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.MEM_ADDR_W(AW)) dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .mem_loadM1  (mem_loadM1),
        .mem_storeM1 (mem_storeM1),
        .resultM1    (resultM1),
        .reg_data2M1 (reg_data2M1),
        .mem_loadM2  (mem_loadM2),
        .mem_storeM2 (mem_storeM2),
        .resultM2    (resultM2),
        .reg_data2M2 (reg_data2M2),
        .stall       (stall),
        .load_dataW1 (load_dataW1),
        .load_dataW2 (load_dataW2),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{mem_we[b]}};
    end

    // Synchronous RAM: read returns the word as it was before this edge's write.
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we != 4'b0000)
                ram[mem_addr] <= (ram[mem_addr] & ~wmask) | (mem_wdata & wmask);
            mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] ld, input logic [31:0] word,
                                               input logic [1:0] off);
        logic [31:0] b, h;
        b = word >> {off, 3'b000};
        h = word >> {off[1], 4'b0000};
        case (ld)
            T_LB:    return {{24{b[7]}}, b[7:0]};
            T_LH:    return {{16{h[15]}}, h[15:0]};
            T_LW:    return word;
            T_LBU:   return {24'h0, b[7:0]};
            T_LHU:   return {16'h0, h[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] st, input logic [31:0] word,
                                                input logic [1:0] off, input logic [31:0] d);
        logic [31:0] r;
        r = word;
        case (st)
            S_SB:    r[{off, 3'b000} +: 8] = d[7:0];
            S_SH:    r[{off[1], 4'b0000} +: 16] = d[15:0];
            S_SW:    r = d;
            default: r = word;
        endcase
        return r;
    endfunction

    // Present one pair for a cycle (two if stalled) and capture W-stage data after it.
    task automatic issue_pair(input logic [2:0] l1, input logic [1:0] s1, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [2:0] l2, input logic [1:0] s2,
                              input logic [31:0] a2, input logic [31:0] d2);
        @(negedge CLK);
        mem_loadM1 = l1; mem_storeM1 = s1; resultM1 = a1; reg_data2M1 = d1;
        mem_loadM2 = l2; mem_storeM2 = s2; resultM2 = a2; reg_data2M2 = d2;
        #1;
        st0 = stall; en0 = mem_en; we0 = mem_we; ad0 = mem_addr;
        st1 = 1'b0; we1 = 4'b0000;
        @(posedge CLK);
        if (st0) begin
            @(negedge CLK);
            #1;
            st1 = stall; we1 = mem_we;
            @(posedge CLK);
        end
        #1;
        w1 = load_dataW1; w2 = load_dataW2;
    endtask

    task automatic test_reset();
        mem_loadM1 = T_LW; resultM1 = 32'h10;
        mem_storeM2 = S_SW; resultM2 = 32'h14;
        #2 NRST = 1'b0;
        @(negedge CLK); #1;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
        n_total++; if (mem_we !== 4'b0000) $display("FAIL reset_mem_we: got %b want 0000", mem_we); else n_pass++;
        n_total++; if (load_dataW1 !== 32'h0) $display("FAIL reset_w1: got %h want 0", load_dataW1); else n_pass++;
        n_total++; if (load_dataW2 !== 32'h0) $display("FAIL reset_w2: got %h want 0", load_dataW2); else n_pass++;
        mem_loadM1 = T_NONE; mem_storeM2 = S_NONE;
        @(negedge CLK);
        NRST = 1'b1;
    endtask

    task automatic test_single_store_load();
        issue_pair(T_NONE, S_SW, 32'h100, 32'hDEADBEEF, T_NONE, S_NONE, 32'h0, 32'h0);
        n_total++; if (st0 !== 1'b0) $display("FAIL sw_stall: got %b want 0", st0); else n_pass++;
        n_total++; if (en0 !== 1'b1) $display("FAIL sw_en: got %b want 1", en0); else n_pass++;
        n_total++; if (we0 !== 4'b1111) $display("FAIL sw_we: got %b want 1111", we0); else n_pass++;
        n_total++; if (ad0 !== 14'h40) $display("FAIL sw_addr: got %h want 40", ad0); else n_pass++;
        issue_pair(T_LW, S_NONE, 32'h100, 32'h0, T_NONE, S_NONE, 32'h0, 32'h0);
        n_total++; if (w1 !== 32'hDEADBEEF) $display("FAIL lw_w1: got %h want deadbeef", w1); else n_pass++;
        n_total++; if (w2 !== 32'h0) $display("FAIL lw_w2_idle: got %h want 0", w2); else n_pass++;
    endtask

    task automatic test_same_word();
        issue_pair(T_LB, S_NONE, 32'h101, 32'h0, T_LBU, S_NONE, 32'h101, 32'h0);
        n_total++; if (st0 !== 1'b0) $display("FAIL sameword_stall: got %b want 0", st0); else n_pass++;
        n_total++; if (w1 !== 32'hFFFFFFBE) $display("FAIL sameword_lb: got %h want ffffffbe", w1); else n_pass++;
        n_total++; if (w2 !== 32'h000000BE) $display("FAIL sameword_lbu: got %h want 000000be", w2); else n_pass++;
        // Same word, different offsets: still one access.
        issue_pair(T_LH, S_NONE, 32'h100, 32'h0, T_LBU, S_NONE, 32'h103, 32'h0);
        n_total++; if (st0 !== 1'b0) $display("FAIL sameword2_stall: got %b want 0", st0); else n_pass++;
        n_total++; if (w1 !== 32'hFFFFBEEF) $display("FAIL sameword2_lh: got %h want ffffbeef", w1); else n_pass++;
        n_total++; if (w2 !== 32'h000000DE) $display("FAIL sameword2_lbu: got %h want 000000de", w2); else n_pass++;
    endtask

    task automatic test_conflict_store_load();
        issue_pair(T_NONE, S_SB, 32'h102, 32'h00000055, T_LW, S_NONE, 32'h100, 32'h0);
        n_total++; if (st0 !== 1'b1) $display("FAIL sb_lw_stall: got %b want 1", st0); else n_pass++;
        n_total++; if (we0 !== 4'b0100) $display("FAIL sb_lw_we: got %b want 0100", we0); else n_pass++;
        n_total++; if (st1 !== 1'b0) $display("FAIL sb_lw_stall2: got %b want 0", st1); else n_pass++;
        n_total++; if (w1 !== 32'h0) $display("FAIL sb_lw_w1: got %h want 0", w1); else n_pass++;
        n_total++; if (w2 !== 32'hDE55BEEF) $display("FAIL sb_lw_w2: got %h want de55beef", w2); else n_pass++;
    endtask

    task automatic test_load_then_store();
        issue_pair(T_LH, S_NONE, 32'h102, 32'h0, T_NONE, S_SH, 32'h102, 32'h00001234);
        n_total++; if (st0 !== 1'b1) $display("FAIL lh_sh_stall: got %b want 1", st0); else n_pass++;
        n_total++; if (we0 !== 4'b0000) $display("FAIL lh_sh_we0: got %b want 0000", we0); else n_pass++;
        n_total++; if (we1 !== 4'b1100) $display("FAIL lh_sh_we1: got %b want 1100", we1); else n_pass++;
        n_total++; if (w1 !== 32'hFFFFDE55) $display("FAIL lh_sh_w1: got %h want ffffde55", w1); else n_pass++;
        // Upper half now 0x1234; lanes 0/1 keep 0xBEEF.
        issue_pair(T_LW, S_NONE, 32'h100, 32'h0, T_NONE, S_NONE, 32'h0, 32'h0);
        n_total++; if (w1 !== 32'h1234BEEF) $display("FAIL sh_readback: got %h want 1234beef", w1); else n_pass++;
        // lhu at an odd address reads the same half.
        issue_pair(T_NONE, S_NONE, 32'h0, 32'h0, T_LHU, S_NONE, 32'h103, 32'h0);
        n_total++; if (w2 !== 32'h00001234) $display("FAIL lhu_odd: got %h want 00001234", w2); else n_pass++;
    endtask

    task automatic test_reset_in_second();
        issue_pair(T_NONE, S_NONE, 32'h0, 32'h0, T_NONE, S_SW, 32'h104, 32'h0BADC0DE);
        n_total++; if (we0 !== 4'b1111) $display("FAIL s2_sw_we: got %b want 1111", we0); else n_pass++;
        n_total++; if (ad0 !== 14'h41) $display("FAIL s2_sw_addr: got %h want 41", ad0); else n_pass++;
        @(negedge CLK);
        mem_loadM1 = T_LW; mem_storeM1 = S_NONE; resultM1 = 32'h100;
        mem_loadM2 = T_NONE; mem_storeM2 = S_SW; resultM2 = 32'h104; reg_data2M2 = 32'hCAFEF00D;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL rst2_pre_stall: got %b want 1", stall); else n_pass++;
        @(negedge CLK);
        NRST = 1'b0;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL rst2_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (mem_we !== 4'b0000) $display("FAIL rst2_we: got %b want 0000", mem_we); else n_pass++;
        n_total++; if (load_dataW1 !== 32'h0) $display("FAIL rst2_w1: got %h want 0", load_dataW1); else n_pass++;
        mem_loadM1 = T_NONE; mem_storeM2 = S_NONE;
        @(negedge CLK);
        NRST = 1'b1;
        issue_pair(T_LW, S_NONE, 32'h104, 32'h0, T_NONE, S_NONE, 32'h0, 32'h0);
        n_total++; if (st0 !== 1'b0) $display("FAIL rst2_after_stall: got %b want 0", st0); else n_pass++;
        n_total++; if (w1 !== 32'h0BADC0DE) $display("FAIL rst2_readback: got %h want 0badc0de", w1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2, d1, d2, e1, e2;
        logic [2:0]  l1, l2;
        logic [1:0]  s1, s2;
        int          k1, k2;
        logic        exp_stall;
        for (int i = 0; i < 4; i++) begin
            d1 = $urandom;
            model_mem[i] = d1;
            issue_pair(T_NONE, S_SW, 32'h200 + 32'(4 * i), d1, T_NONE, S_NONE, 32'h0, 32'h0);
        end
        for (int n = 0; n < 20; n++) begin
            k1 = int'($urandom_range(0, 2));
            k2 = int'($urandom_range(0, 2));
            if (k1 == 0 && k2 == 0) k1 = 1;
            a1 = 32'h200 + $urandom_range(0, 15);
            a2 = 32'h200 + $urandom_range(0, 15);
            if (k1 == 1 && k2 == 1 && $urandom_range(0, 1) == 1) a2 = {a1[31:2], a2[1:0]};
            l1 = (k1 == 1) ? 3'($urandom_range(1, 5)) : T_NONE;
            s1 = (k1 == 2) ? 2'($urandom_range(1, 3)) : S_NONE;
            l2 = (k2 == 1) ? 3'($urandom_range(1, 5)) : T_NONE;
            s2 = (k2 == 2) ? 2'($urandom_range(1, 3)) : S_NONE;
            d1 = $urandom;
            d2 = $urandom;
            exp_stall = (k1 != 0) && (k2 != 0) && !(k1 == 1 && k2 == 1 && a1[31:2] == a2[31:2]);
            // Program order: slot 1 completes before slot 2.
            e1 = model_load(l1, model_mem[a1[3:2]], a1[1:0]);
            model_mem[a1[3:2]] = model_store(s1, model_mem[a1[3:2]], a1[1:0], d1);
            e2 = model_load(l2, model_mem[a2[3:2]], a2[1:0]);
            model_mem[a2[3:2]] = model_store(s2, model_mem[a2[3:2]], a2[1:0], d2);
            issue_pair(l1, s1, a1, d1, l2, s2, a2, d2);
            n_total++; if (st0 !== exp_stall) $display("FAIL b2b_stall[%0d]: got %b want %b", n, st0, exp_stall); else n_pass++;
            if (st0) begin
                n_total++; if (st1 !== 1'b0) $display("FAIL b2b_double_stall[%0d]: got %b want 0", n, st1); else n_pass++;
            end
            n_total++; if (w1 !== e1) $display("FAIL b2b_w1[%0d]: got %h want %h", n, w1, e1); else n_pass++;
            n_total++; if (w2 !== e2) $display("FAIL b2b_w2[%0d]: got %h want %h", n, w2, e2); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_store_load();
        test_same_word();
        test_conflict_store_load();
        test_load_then_store();
        test_reset_in_second();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
